// File: rtl/vc_buffer_pkg.sv
// rtl/vc_buffer_pkg.sv - shared types and helpers for the multi-VC input buffer
package vc_buffer_pkg;

    // Per-lane status bundle reported to the VC allocator
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
    } lane_status_t;

    // Select-field width for n lanes; a single lane still needs one bit
    function automatic int vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_buffer_lane.sv
// rtl/vc_buffer_lane.sv - one circular FIFO lane with show-ahead head output
module vc_buffer_lane
    import vc_buffer_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int AFULL_LEVEL = 2,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      count,
    output lane_status_t          status
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Next-state: enables are pre-qualified by the top, so apply them unconditionally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage clears too so dout reads 0 after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout               = mem_q[rd_ptr_q];
    assign count              = count_q;
    assign status.empty       = (count_q == '0);
    assign status.full        = (count_q == CNT_W'(DEPTH));
    assign status.almost_full = (count_q >= CNT_W'(AFULL_LEVEL));

endmodule

// File: rtl/vc_buffer.sv
// rtl/vc_buffer.sv - multi-VC router input buffer top (optional VC_BUFFER_ERR_EN error flags)
module vc_buffer
    import vc_buffer_pkg::*;
#(
    parameter int  NUM_VC      = 2,
    parameter int  DEPTH       = 3,
    parameter int  DATA_WIDTH  = 32,
    parameter int  AFULL_LEVEL = 2,
    localparam int VC_W        = vc_w(NUM_VC),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [VC_W-1:0]         push_vc,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    pop,
    input  logic [VC_W-1:0]         pop_vc,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
`ifdef VC_BUFFER_ERR_EN
    output logic [NUM_VC-1:0]       err_ovf,
    output logic [NUM_VC-1:0]       err_udf,
`endif
    output logic [NUM_VC*CNT_W-1:0] count
);

    logic [NUM_VC-1:0]     push_sel, pop_sel, wr_en, rd_en;
    logic [DATA_WIDTH-1:0] lane_dout   [NUM_VC];
    lane_status_t          lane_status [NUM_VC];

    // Decode lane selects; out-of-range selects match no lane and become no access
    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        rd_en    = '0;
        wr_en    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            push_sel[i] = push && (push_vc == VC_W'(i));
            pop_sel[i]  = pop && (pop_vc == VC_W'(i));
            rd_en[i]    = pop_sel[i] && !lane_status[i].empty;
            // A full lane still accepts the write when it is drained in the same cycle
            wr_en[i]    = push_sel[i] && (!lane_status[i].full || rd_en[i]);
        end
    end

    // Show-ahead read mux; an unmatched pop_vc reads 0
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pop_vc == VC_W'(i)) dout = lane_dout[i];
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
        vc_buffer_lane #(
            .DEPTH       (DEPTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .AFULL_LEVEL (AFULL_LEVEL),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (wr_en[g]),
            .rd_en  (rd_en[g]),
            .din    (din),
            .dout   (lane_dout[g]),
            .count  (count[g*CNT_W +: CNT_W]),
            .status (lane_status[g])
        );
        assign empty[g]       = lane_status[g].empty;
        assign full[g]        = lane_status[g].full;
        assign almost_full[g] = lane_status[g].almost_full;
    end

`ifdef VC_BUFFER_ERR_EN
    logic [NUM_VC-1:0] err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    // Sticky flags: dropped push marks overflow, ignored pop marks underflow
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        for (int i = 0; i < NUM_VC; i++) begin
            if (push_sel[i] && !wr_en[i]) err_ovf_d[i] = 1'b1;
            if (pop_sel[i] && !rd_en[i])  err_udf_d[i] = 1'b1;
        end
    end

    // Flag registers clear only on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q <= '0;
            err_udf_q <= '0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule
